// File: rtl/skid_pkg.sv
// Shared constants for the skid buffer: FSM state encodings and occupancy levels.
package skid_pkg;

    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_BUSY  = 2'b01;
    localparam logic [1:0] SKID_FULL  = 2'b10;

    localparam logic [1:0] LEVEL_ZERO = 2'd0;
    localparam logic [1:0] LEVEL_ONE  = 2'd1;
    localparam logic [1:0] LEVEL_TWO  = 2'd2;

    function automatic logic [1:0] state_level(input logic [1:0] st);
        case (st)
            SKID_BUSY: return LEVEL_ONE;
            SKID_FULL: return LEVEL_TWO;
            default:   return LEVEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/dff.sv
// Enabled data register with selectable sync/async reset and reset polarity; resets to zero.
module dff #(
    parameter int unsigned WIDTH          = 8,
    parameter bit          ASYNC_RESET    = 1'b1,
    parameter bit          RESET_POLARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (ASYNC_RESET && !RESET_POLARITY) begin : g_async_low
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= d;
                end
            end
        end else if (ASYNC_RESET) begin : g_async_high
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= d;
                end
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst == RESET_POLARITY) begin
                    q <= '0;
                end else if (en) begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/skid_buffer.sv
// Two-entry ready/valid register slice: in_ready and out_valid come from registered state only,
// so there is no combinational path from out_ready back to in_ready.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [1:0]       state_q, state_d;
    logic             in_fire, out_fire;
    logic             main_en, main_from_skid, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;

    assign out_valid = (state_q != SKID_EMPTY);
    assign in_ready  = (state_q != SKID_FULL);
    assign level     = state_level(state_q);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (flush) begin
            // Flush wins over any handshake; a beat accepted this cycle is dropped.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        state_d = SKID_BUSY;
                        main_en = 1'b1;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state_d = SKID_FULL;
                        skid_en = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d = SKID_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        state_d        = SKID_BUSY;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    dff #(
        .WIDTH         (WIDTH),
        .ASYNC_RESET   (1'b1),
        .RESET_POLARITY(1'b0)
    ) u_main_reg (
        .clk(clk),
        .rst(rst),
        .en (main_en),
        .d  (main_d),
        .q  (out_data)
    );

    dff #(
        .WIDTH         (WIDTH),
        .ASYNC_RESET   (1'b1),
        .RESET_POLARITY(1'b0)
    ) u_skid_reg (
        .clk(clk),
        .rst(rst),
        .en (skid_en),
        .d  (in_data),
        .q  (skid_q)
    );

endmodule
